// File: rtl/dma_arb_pkg.sv
// Shared types and helpers for the DMA channel priority arbiter.
// Contents:
//   NUM_CH_DEF / CH_W_DEF  default channel count and channel-index width
//   MAX_CH                 widest channel vector the one-hot helper can build
//   arb_state_e            bus-request sequencer states
//   dack_onehot()          active-high one-hot pattern for a channel index
package dma_arb_pkg;

  localparam int unsigned NUM_CH_DEF = 4;
  localparam int unsigned CH_W_DEF   = $clog2(NUM_CH_DEF);
  localparam int unsigned MAX_CH     = 32;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_HLDA = 2'd1,
    ACTIVE    = 2'd2,
    RELEASE   = 2'd3
  } arb_state_e;

  // Callers truncate the result to their own channel count.
  function automatic logic [MAX_CH-1:0] dack_onehot(input int unsigned ch);
    return MAX_CH'(1) << ch;
  endfunction

endpackage

// File: rtl/dma_rotate_pick.sv
// Combinational priority picker for the DMA arbiter.
// Searches req starting at startCh and wrapping around; in fixed mode the
// search always starts at channel 0 so the lowest index wins.
// Ports:
//   req       in  NUM_CH  effective channel requests
//   startCh   in  CH_W    first channel searched in rotating mode
//   rotating  in  1       1 = rotating priority, 0 = fixed priority
//   found     out 1       at least one channel is requesting
//   winCh     out CH_W    index of the winning channel (0 when none)
module dma_rotate_pick
  import dma_arb_pkg::*;
#(
  parameter int unsigned NUM_CH = NUM_CH_DEF,
  parameter int unsigned CH_W   = $clog2(NUM_CH)
) (
  input  logic [NUM_CH-1:0] req,
  input  logic [CH_W-1:0]   startCh,
  input  logic              rotating,
  output logic              found,
  output logic [CH_W-1:0]   winCh
);

  logic [CH_W-1:0] base;
  logic [CH_W-1:0] idx;

  // NUM_CH is a power of two, so the CH_W-bit add wraps modulo NUM_CH.
  always_comb begin
    found = 1'b0;
    winCh = '0;
    idx   = '0;
    base  = rotating ? startCh : '0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      idx = base + CH_W'(i);
      if (!found && req[idx]) begin
        found = 1'b1;
        winCh = idx;
      end
    end
  end

endmodule

// File: rtl/dma_priority_arbiter.sv
// Channel priority and bus-request sequencer for the 4-channel DMA controller.
// Merges masked hardware DREQs with software requests, requests the bus with
// HRQ, and on HLDA grants one channel (fixed or rotating priority) until
// timing-and-control signals the end of service. NUM_CH must be a power of
// two and at least 2.
// Ports:
//   CLK, RESET_N       clock, asynchronous active-low reset
//   DREQ               raw channel requests (polarity from dreqActiveLow)
//   swReq              software request bits, unaffected by mask
//   mask               1 blocks that channel's DREQ
//   dreqActiveLow      1 = DREQ asserted low
//   dackActiveHigh     1 = DACK asserted high
//   rotatingPriority   0 = fixed, 1 = rotating priority
//   ctrlDisable        blocks all new requests
//   HLDA               hold acknowledge from the CPU
//   xferDone           end-of-service pulse from timing-and-control
//   HRQ                hold request to the CPU
//   DACK               one-hot channel acknowledge
//   grantValid         a channel owns the bus
//   grantCh            index of the granted channel
//   swReqClr           one-cycle pulse clearing the served swReq bit
module dma_priority_arbiter
  import dma_arb_pkg::*;
#(
  parameter int unsigned NUM_CH = NUM_CH_DEF,
  parameter int unsigned CH_W   = $clog2(NUM_CH)
) (
  input  logic              CLK,
  input  logic              RESET_N,
  input  logic [NUM_CH-1:0] DREQ,
  input  logic [NUM_CH-1:0] swReq,
  input  logic [NUM_CH-1:0] mask,
  input  logic              dreqActiveLow,
  input  logic              dackActiveHigh,
  input  logic              rotatingPriority,
  input  logic              ctrlDisable,
  input  logic              HLDA,
  input  logic              xferDone,
  output logic              HRQ,
  output logic [NUM_CH-1:0] DACK,
  output logic              grantValid,
  output logic [CH_W-1:0]   grantCh,
  output logic [NUM_CH-1:0] swReqClr
);

  arb_state_e        state_q, state_d;
  logic              hrq_q, hrq_d;
  logic              gv_q, gv_d;
  logic [CH_W-1:0]   gch_q, gch_d;
  logic [CH_W-1:0]   low_q, low_d;
  logic [NUM_CH-1:0] dack_q, dack_d;
  logic [NUM_CH-1:0] clr_q, clr_d;

  logic [NUM_CH-1:0] eff_req;
  logic [CH_W-1:0]   start_ch;
  logic              found;
  logic [CH_W-1:0]   win_ch;

  // Hardware requests normalised to active-high and masked; software
  // requests bypass the mask; the disable bit blocks everything.
  assign eff_req  = ctrlDisable ? '0
                  : (((DREQ ^ {NUM_CH{dreqActiveLow}}) & ~mask) | swReq);
  assign start_ch = low_q + CH_W'(1);

  dma_rotate_pick #(
    .NUM_CH (NUM_CH),
    .CH_W   (CH_W)
  ) u_pick (
    .req      (eff_req),
    .startCh  (start_ch),
    .rotating (rotatingPriority),
    .found    (found),
    .winCh    (win_ch)
  );

  // Next-state and next-output logic.
  always_comb begin
    state_d = state_q;
    hrq_d   = hrq_q;
    gv_d    = gv_q;
    gch_d   = gch_q;
    low_d   = low_q;
    dack_d  = dack_q;
    clr_d   = '0;
    case (state_q)
      IDLE: begin
        if (found) begin
          state_d = WAIT_HLDA;
          hrq_d   = 1'b1;
        end
      end
      WAIT_HLDA: begin
        if (HLDA && found) begin
          state_d = ACTIVE;
          gv_d    = 1'b1;
          gch_d   = win_ch;
          dack_d  = NUM_CH'(dack_onehot(32'(win_ch)));
        end else if (HLDA) begin
          // Bus arrived but every request vanished: hand it straight back.
          state_d = RELEASE;
          hrq_d   = 1'b0;
        end else if (!found) begin
          state_d = IDLE;
          hrq_d   = 1'b0;
        end
      end
      ACTIVE: begin
        // Completion wins over a simultaneous HLDA drop.
        if (xferDone || !HLDA) begin
          state_d = RELEASE;
          hrq_d   = 1'b0;
          gv_d    = 1'b0;
          dack_d  = '0;
          if (xferDone) begin
            clr_d = NUM_CH'(dack_onehot(32'(gch_q)));
            if (rotatingPriority) begin
              low_d = gch_q;
            end
          end
        end
      end
      RELEASE: begin
        hrq_d = 1'b0;
        if (!HLDA) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
        hrq_d   = 1'b0;
        gv_d    = 1'b0;
        dack_d  = '0;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q <= IDLE;
      hrq_q   <= 1'b0;
      gv_q    <= 1'b0;
      gch_q   <= '0;
      low_q   <= CH_W'(NUM_CH - 1);
      dack_q  <= '0;
      clr_q   <= '0;
    end else begin
      state_q <= state_d;
      hrq_q   <= hrq_d;
      gv_q    <= gv_d;
      gch_q   <= gch_d;
      low_q   <= low_d;
      dack_q  <= dack_d;
      clr_q   <= clr_d;
    end
  end

  // The acknowledge itself is registered active-high; the static polarity
  // bit only inverts it, so DACK is inactive for either polarity in reset.
  assign DACK       = dack_q ^ {NUM_CH{~dackActiveHigh}};
  assign HRQ        = hrq_q;
  assign grantValid = gv_q;
  assign grantCh    = gch_q;
  assign swReqClr   = clr_q;

endmodule

// File: tb/tb_dma_priority_arbiter.sv
// Self-checking bench for dma_priority_arbiter: directed scenarios followed
// by randomized transactions, checked against a transaction-level model.
module tb_dma_priority_arbiter;

  localparam int N = 4;
  localparam int W = 2;

  logic         CLK = 1'b0;
  logic         RESET_N;
  logic [N-1:0] DREQ, swReq, mask;
  logic         dreqActiveLow, dackActiveHigh, rotatingPriority, ctrlDisable;
  logic         HLDA, xferDone;
  logic         HRQ, grantValid;
  logic [N-1:0] DACK, swReqClr;
  logic [W-1:0] grantCh;

  int checks   = 0;
  int failures = 0;
  int model_low = N - 1;

  dma_priority_arbiter #(.NUM_CH(N), .CH_W(W)) dut (
    .CLK              (CLK),
    .RESET_N          (RESET_N),
    .DREQ             (DREQ),
    .swReq            (swReq),
    .mask             (mask),
    .dreqActiveLow    (dreqActiveLow),
    .dackActiveHigh   (dackActiveHigh),
    .rotatingPriority (rotatingPriority),
    .ctrlDisable      (ctrlDisable),
    .HLDA             (HLDA),
    .xferDone         (xferDone),
    .HRQ              (HRQ),
    .DACK             (DACK),
    .grantValid       (grantValid),
    .grantCh          (grantCh),
    .swReqClr         (swReqClr)
  );

  always #5 CLK = ~CLK;

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic check_eq(input string tag, input int got, input int want);
    checks++;
    if (got != want) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h at %0t", tag, got, want, $time);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Effective requests straight from the bit-level rules.
  function automatic logic [N-1:0] model_eff();
    logic [N-1:0] r;
    logic hw;
    for (int i = 0; i < N; i++) begin
      hw   = dreqActiveLow ? !DREQ[i] : DREQ[i];
      r[i] = !ctrlDisable && ((hw && !mask[i]) || swReq[i]);
    end
    return r;
  endfunction

  function automatic int model_pick(input logic [N-1:0] e);
    int c;
    if (!rotatingPriority) begin
      for (int k = 0; k < N; k++) if (e[k]) return k;
    end else begin
      for (int k = 1; k <= N; k++) begin
        c = (model_low + k) % N;
        if (e[c]) return c;
      end
    end
    return -1;
  endfunction

  // Expected DACK pins for a granted channel (-1 = nothing granted).
  function automatic logic [N-1:0] dack_exp(input int ch);
    logic [N-1:0] r;
    for (int i = 0; i < N; i++) r[i] = dackActiveHigh ? (i == ch) : (i != ch);
    return r;
  endfunction

  // One full request/grant/release transaction. mode: 0 xferDone,
  // 1 abort by HLDA drop, 2 xferDone with simultaneous HLDA drop.
  // want >= 0 pins the expected channel, otherwise the model decides.
  task automatic xfer(input logic [N-1:0] dreq, input logic [N-1:0] sw,
                      input logic [N-1:0] msk, input logic dal, input logic dah,
                      input logic rot, input logic dis, input int dly,
                      input int hold, input int mode, input int want,
                      input bit churn);
    logic [N-1:0] e, oh;
    int exp_ch;
    DREQ = dreq; swReq = sw; mask = msk;
    dreqActiveLow = dal; dackActiveHigh = dah;
    rotatingPriority = rot; ctrlDisable = dis;
    e = model_eff();
    tick();
    if (e == '0) begin
      check_eq("hrq_norequest", int'(HRQ), 0);
      tick();
      check_eq("hrq_norequest2", int'(HRQ), 0);
      check_eq("dack_norequest", int'(DACK), int'(dack_exp(-1)));
      return;
    end
    check_eq("hrq_rise", int'(HRQ), 1);
    check_eq("gv_wait", int'(grantValid), 0);
    for (int i = 0; i < dly; i++) begin
      if (churn) begin
        swReq    = swReq | N'($urandom);
        xferDone = 1'($urandom);
      end
      tick();
      xferDone = 1'b0;
      check_eq("hrq_wait", int'(HRQ), 1);
      check_eq("dack_wait", int'(DACK), int'(dack_exp(-1)));
    end
    HLDA = 1'b1;
    e = model_eff();
    exp_ch = (want >= 0) ? want : model_pick(e);
    tick();
    check_eq("gv_grant", int'(grantValid), 1);
    check_eq("grant_ch", int'(grantCh), exp_ch);
    check_eq("dack_grant", int'(DACK), int'(dack_exp(exp_ch)));
    check_eq("hrq_grant", int'(HRQ), 1);
    for (int i = 0; i < hold; i++) begin
      if (churn) DREQ = N'($urandom);
      tick();
      check_eq("grant_ch_hold", int'(grantCh), exp_ch);
      check_eq("dack_hold", int'(DACK), int'(dack_exp(exp_ch)));
    end
    if (mode != 1) xferDone = 1'b1;
    if (mode != 0) HLDA = 1'b0;
    tick();
    xferDone = 1'b0;
    oh = '0;
    if (mode != 1) oh[exp_ch] = 1'b1;
    check_eq("hrq_done", int'(HRQ), 0);
    check_eq("gv_done", int'(grantValid), 0);
    check_eq("dack_done", int'(DACK), int'(dack_exp(-1)));
    check_eq("swreqclr_done", int'(swReqClr), int'(oh));
    if (mode != 1) begin
      swReq = swReq & ~oh;
      if (rot) model_low = exp_ch;
    end
    tick();
    check_eq("swreqclr_pulse", int'(swReqClr), 0);
    check_eq("hrq_release", int'(HRQ), 0);
    if (HLDA) begin
      if ($urandom_range(1, 0) == 1) begin
        tick();
        check_eq("hrq_release_hold", int'(HRQ), 0);
      end
      HLDA = 1'b0;
      tick();
      check_eq("hrq_release_end", int'(HRQ), 0);
    end
  endtask

  initial begin
    RESET_N = 1'b0;
    DREQ = '0; swReq = '0; mask = '0;
    dreqActiveLow = 1'b0; dackActiveHigh = 1'b1;
    rotatingPriority = 1'b0; ctrlDisable = 1'b0;
    HLDA = 1'b0; xferDone = 1'b0;

    // Reset values, DACK inactive for both polarities.
    #12;
    check_eq("rst_hrq", int'(HRQ), 0);
    check_eq("rst_gv", int'(grantValid), 0);
    check_eq("rst_grantch", int'(grantCh), 0);
    check_eq("rst_swreqclr", int'(swReqClr), 0);
    check_eq("rst_dack_hi", int'(DACK), 0);
    dackActiveHigh = 1'b0;
    #1;
    check_eq("rst_dack_lo", int'(DACK), 'hF);
    dackActiveHigh = 1'b1;
    @(negedge CLK);
    RESET_N = 1'b1;
    tick();

    // Fixed priority: ch1 beats ch3, then ch3 once ch1 drops.
    xfer(4'b1010, 4'b0000, 4'b0000, 0, 1, 0, 0, 2, 2, 0, 1, 0);
    xfer(4'b1000, 4'b0000, 4'b0000, 0, 1, 0, 0, 2, 1, 0, 3, 0);

    // Rotating priority with all channels requesting.
    for (int i = 0; i < 5; i++)
      xfer(4'b1111, 4'b0000, 4'b0000, 0, 1, 1, 0, 1, 1, 0, i % N, 0);

    // Masked hardware request ignored; software request served and cleared.
    xfer(4'b0001, 4'b0000, 4'b0001, 0, 1, 0, 0, 1, 1, 0, -1, 0);
    xfer(4'b0001, 4'b0001, 4'b0001, 0, 1, 0, 0, 1, 1, 0, 0, 0);

    // Polarity: active-low DREQ and DACK.
    xfer(4'b1011, 4'b0000, 4'b0000, 1, 0, 0, 0, 1, 1, 0, 2, 0);

    // Request withdrawn before HLDA.
    DREQ = 4'b0100; dreqActiveLow = 1'b0; dackActiveHigh = 1'b1;
    rotatingPriority = 1'b0; swReq = '0; mask = '0;
    tick();
    check_eq("withdraw_hrq_up", int'(HRQ), 1);
    DREQ = '0;
    tick();
    check_eq("withdraw_hrq_down", int'(HRQ), 0);
    tick();
    check_eq("withdraw_idle", int'(HRQ), 0);

    // Abort leaves rotation pointer alone: ch1 is picked twice.
    xfer(4'b1111, 4'b0000, 4'b0000, 0, 1, 1, 0, 1, 1, 1, 1, 0);
    xfer(4'b1111, 4'b0000, 4'b0000, 0, 1, 1, 0, 1, 1, 0, 1, 0);

    // Asynchronous reset while ch2 holds the bus.
    DREQ = 4'b0100; rotatingPriority = 1'b0; dackActiveHigh = 1'b0;
    tick();
    check_eq("rst_seq_hrq", int'(HRQ), 1);
    HLDA = 1'b1;
    tick();
    check_eq("rst_seq_grant", int'(grantCh), 2);
    check_eq("rst_seq_dack", int'(DACK), 'hB);
    #2;
    RESET_N = 1'b0;
    #1;
    check_eq("async_rst_hrq", int'(HRQ), 0);
    check_eq("async_rst_gv", int'(grantValid), 0);
    check_eq("async_rst_dack", int'(DACK), 'hF);
    check_eq("async_rst_clr", int'(swReqClr), 0);
    HLDA = 1'b0; DREQ = '0;
    #3;
    RESET_N = 1'b1;
    model_low = N - 1;
    tick();
    xfer(4'b1111, 4'b0000, 4'b0000, 0, 1, 1, 0, 1, 1, 0, 0, 0);

    // Randomized transactions.
    for (int t = 0; t < 80; t++) begin
      xfer(N'($urandom),
           ($urandom_range(2, 0) == 0) ? N'($urandom) : N'(0),
           N'($urandom),
           1'($urandom), 1'($urandom), 1'($urandom),
           ($urandom_range(7, 0) == 0),
           $urandom_range(3, 0), $urandom_range(3, 0),
           $urandom_range(2, 0), -1, 1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
